edge_period_lock: RTL and testbench

Measures the cycle count between successive single-cycle falling-edge flags and reports lock once the period is stable. It sits directly downstream of the falling-edge flag generator. It turns that detector's one-cycle pulses into a validated period value, a lock indication and a loss-of-signal timeout for test-bed timing and sync logic.

---
 rtl/edge_period_lock_pkg.sv | 18 +
 rtl/period_tol_cmp.sv | 21 ++
 rtl/edge_period_lock.sv | 155 +++++++++++++++
 tb/tb_edge_period_lock.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_period_lock_pkg.sv
// Shared types and default parameters for the falling-edge period lock block
// and the sync blocks built on top of it.
package edge_period_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEAS   = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } epl_state_e;

    localparam int DEF_CNT_W       = 24;
    localparam int DEF_TOL         = 4;
    localparam int DEF_LOCK_CNT    = 4;
    localparam int DEF_UNLOCK_CNT  = 2;
    localparam int DEF_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/period_tol_cmp.sv
// Combinational period match: |per - ref| <= TOL, evaluated in W+1 bits so the
// difference can never wrap.
module period_tol_cmp #(
    parameter int W   = 24,
    parameter int TOL = 4
) (
    input  logic [W-1:0] per_i,
    input  logic [W-1:0] ref_i,
    output logic         match_o
);

    localparam logic [W:0] TOL_V = (W+1)'(TOL);

    logic [W:0] a, b, diff;

    assign a       = {1'b0, per_i};
    assign b       = {1'b0, ref_i};
    assign diff    = (a >= b) ? (a - b) : (b - a);
    assign match_o = (diff <= TOL_V);

endmodule

// File: rtl/edge_period_lock.sv
// Period measurement between edge flags with lock/unlock hysteresis and a
// loss-of-signal timeout. All outputs are registered.
module edge_period_lock
    import edge_period_lock_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TOL         = DEF_TOL,
    parameter int LOCK_CNT    = DEF_LOCK_CNT,
    parameter int UNLOCK_CNT  = DEF_UNLOCK_CNT,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_edgeFlg,
    output logic [CNT_W-1:0] O_period,
    output logic             O_periodVld,
    output logic             O_locked,
    output logic             O_timeout
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [MW-1:0]    M_ONE    = MW'(1);
    localparam logic [MW-1:0]    M_LOCK   = MW'(LOCK_CNT);
    localparam logic [UW-1:0]    U_ONE    = UW'(1);
    localparam logic [UW-1:0]    U_UNLOCK = UW'(UNLOCK_CNT);

    epl_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic [MW-1:0]    match_q, match_d, match_inc;
    logic [UW-1:0]    miss_q, miss_d, miss_inc;

    logic [CNT_W-1:0] period_q, period_d;
    logic             vld_q, vld_d;
    logic             locked_q, locked_d;
    logic             tmo_q, tmo_d;

    logic [CNT_W-1:0] per;
    logic             match;
    logic             strobe;
    logic             tmo_hit;

    // Edge at cycle t with cnt = N-1 means the previous edge was N cycles ago.
    assign per       = cnt_q + CNT_ONE;
    assign match_inc = match_q + M_ONE;
    assign miss_inc  = miss_q + U_ONE;

    period_tol_cmp #(
        .W   (CNT_W),
        .TOL (TOL)
    ) u_cmp (
        .per_i   (per),
        .ref_i   (ref_q),
        .match_o (match)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ref_q    <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            period_q <= '0;
            vld_q    <= 1'b0;
            locked_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ref_q    <= ref_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            period_q <= period_d;
            vld_q    <= vld_d;
            locked_q <= locked_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        match_d = match_q;
        miss_d  = miss_q;
        strobe  = 1'b0;
        tmo_hit = 1'b0;
        if (I_edgeFlg) begin
            cnt_d = '0;
            unique case (state_q)
                ST_IDLE: state_d = ST_MEAS;
                ST_MEAS: begin
                    strobe  = 1'b1;
                    ref_d   = per;
                    match_d = '0;
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    strobe = 1'b1;
                    ref_d  = per;
                    if (match) begin
                        match_d = match_inc;
                        if (match_inc == M_LOCK) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    strobe = 1'b1;
                    if (match) begin
                        ref_d  = per;
                        miss_d = '0;
                    end else begin
                        miss_d = miss_inc;
                        if (miss_inc == U_UNLOCK) begin
                            state_d = ST_TRACK;
                            ref_d   = per;
                            match_d = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            // Saturate at the timeout point so a silent input never wraps cnt.
            if (cnt_q != CNT_LAST)
                cnt_d = cnt_q + CNT_ONE;
            if (state_q != ST_IDLE && cnt_q == CNT_LAST) begin
                tmo_hit = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        period_d = strobe ? per : period_q;
        vld_d    = strobe;
        locked_d = (state_d == ST_LOCKED);
        tmo_d    = tmo_hit;
    end

    assign O_period    = period_q;
    assign O_periodVld = vld_q;
    assign O_locked    = locked_q;
    assign O_timeout   = tmo_q;

endmodule

// File: tb/tb_edge_period_lock.sv
// Scoreboard bench for edge_period_lock: a behavioural model queues the expected
// outputs for each driven cycle; they are popped and compared after the edge.
module tb_edge_period_lock;

    localparam int CNT_W      = 24;
    localparam int TOL        = 4;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 2;
    localparam int TO_CYC     = 150;

    logic             clk = 1'b0;
    logic             rst;
    logic             edg;
    logic [CNT_W-1:0] period;
    logic             vld, locked, tmo;

    always #5 clk = ~clk;

    edge_period_lock #(
        .CNT_W       (CNT_W),
        .TOL         (TOL),
        .LOCK_CNT    (LOCK_CNT),
        .UNLOCK_CNT  (UNLOCK_CNT),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .I_clk       (clk),
        .I_rst       (rst),
        .I_edgeFlg   (edg),
        .O_period    (period),
        .O_periodVld (vld),
        .O_locked    (locked),
        .O_timeout   (tmo)
    );

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic             vld;
        logic             locked;
        logic             tmo;
    } obs_t;

    obs_t exp_q[$];
    obs_t m_out;
    int   m_st, m_cnt, m_ref, m_match, m_miss;
    int   n_chk = 0, n_fail = 0;
    int   n_vld, n_tmo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour: states 0=idle 1=meas 2=track 3=locked.
    task automatic model(input logic e, input logic r);
        int p, d;
        m_out.vld = 1'b0;
        m_out.tmo = 1'b0;
        if (r) begin
            m_st = 0; m_cnt = 0; m_ref = 0; m_match = 0; m_miss = 0;
            m_out = '0;
        end else begin
            p = m_cnt + 1;
            d = (p > m_ref) ? p - m_ref : m_ref - p;
            if (e) begin
                if (m_st != 0) begin
                    m_out.vld    = 1'b1;
                    m_out.period = p[CNT_W-1:0];
                end
                case (m_st)
                    0: m_st = 1;
                    1: begin m_ref = p; m_match = 0; m_st = 2; end
                    2: begin
                        if (d <= TOL) begin
                            m_match++;
                            if (m_match == LOCK_CNT) begin m_st = 3; m_miss = 0; end
                        end else m_match = 0;
                        m_ref = p;
                    end
                    default: begin
                        if (d <= TOL) begin m_ref = p; m_miss = 0; end
                        else begin
                            m_miss++;
                            if (m_miss == UNLOCK_CNT) begin m_st = 2; m_ref = p; m_match = 0; end
                        end
                    end
                endcase
                m_cnt = 0;
            end else begin
                if (m_st != 0 && m_cnt == TO_CYC - 1) begin
                    m_out.tmo = 1'b1;
                    m_st = 0;
                end
                if (m_cnt < TO_CYC - 1) m_cnt++;
            end
            m_out.locked = (m_st == 3);
        end
        exp_q.push_back(m_out);
    endtask

    task automatic tick(input logic e, input logic r = 1'b0);
        obs_t want;
        edg = e;
        rst = r;
        model(e, r);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        chk("sb_out", {period, vld, locked, tmo}, want);
        if (vld) n_vld++;
        if (tmo) n_tmo++;
    endtask

    task automatic gap(input int n);
        repeat (n - 1) tick(1'b0);
        tick(1'b1);
    endtask

    int tmo_at;
    int g;

    initial begin
        edg = 1'b0;
        rst = 1'b1;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("rst_period", period, 0);
        chk("rst_vld", vld, 0);
        chk("rst_locked", locked, 0);
        chk("rst_tmo", tmo, 0);

        // Steady 100-cycle stream: lock on the 6th edge
        tick(1'b1);
        chk("edge1_nostrobe", vld, 0);
        gap(100);
        chk("edge2_vld", vld, 1);
        chk("edge2_period", period, 100);
        repeat (3) gap(100);
        chk("edge5_unlocked", locked, 0);
        gap(100);
        chk("edge6_locked", locked, 1);

        // Hysteresis: 96 is a single miss, then back in tolerance
        gap(104); chk("p104_lock", locked, 1);
        gap(96);  chk("p96_lock", locked, 1);
        gap(105); chk("p105a_lock", locked, 1);
        gap(105); chk("p105b_lock", locked, 1);
        gap(112); chk("miss1_lock", locked, 1);
        gap(112); chk("miss2_unlock", locked, 0);
        chk("miss2_period", period, 112);
        // Back in TRACK with ref=112: four matches relock
        repeat (3) gap(112);
        chk("track_unlocked", locked, 0);
        gap(112);
        chk("track_relock", locked, 1);

        // Reset coincident with an edge
        repeat (99) tick(1'b0);
        tick(1'b1, 1'b1);
        chk("rst_edge_out", {period, vld, locked, tmo}, 0);
        repeat (5) gap(100);
        chk("relock5_no", locked, 0);
        gap(100);
        chk("relock6_yes", locked, 1);

        // Silence from locked: exactly one timeout, lock dropped, period kept
        n_tmo = 0;
        repeat (TO_CYC + 20) tick(1'b0);
        chk("tmo_once", n_tmo, 1);
        chk("tmo_unlock", locked, 0);
        chk("tmo_keep_period", period, 100);

        // Edges 20 apart, then silence
        gap(10);
        chk("idle_edge_nostrobe", vld, 0);
        gap(20);
        chk("p20_period", period, 20);
        tmo_at = 0;
        for (int i = 1; i <= TO_CYC + 10; i++) begin
            tick(1'b0);
            if (tmo && tmo_at == 0) tmo_at = i;
        end
        chk("tmo_cycle", tmo_at, TO_CYC);
        n_vld = 0;
        tick(1'b1);
        chk("post_tmo_nostrobe", n_vld, 0);

        // Edge exactly at the timeout point wins
        n_tmo = 0;
        gap(TO_CYC);
        chk("limit_vld", vld, 1);
        chk("limit_period", period, TO_CYC);
        chk("limit_no_tmo", n_tmo, 0);

        // Flag held high 3 cycles from IDLE
        repeat (TO_CYC + 5) tick(1'b0);
        n_vld = 0;
        tick(1'b1);
        tick(1'b1);
        chk("hold_p1", period, 1);
        tick(1'b1);
        tick(1'b0);
        chk("hold_strobes", n_vld, 2);
        chk("hold_period", period, 1);

        // Jittered stream around 40 cycles with occasional drop-outs
        for (int k = 0; k < 80; k++) begin
            if (k % 25 == 24) g = TO_CYC + 7;
            else g = 40 + $urandom_range(0, 12) - 6;
            gap(g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
